// File: rtl/servo_pkg.sv
// Shared types and constants for the door servo PWM generator and its feedback monitor.
package servo_pkg;

  localparam int unsigned NOM_OPEN_CYC   = 32'd75_000;
  localparam int unsigned NOM_CLOSE_CYC  = 32'd170_000;
  localparam int unsigned NOM_PERIOD_CYC = 32'd1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [1:0] DOOR_UNKNOWN = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSED  = 2'b10;
  localparam logic [1:0] DOOR_BAD     = 2'b11;

endpackage

// File: rtl/servo_pwm_monitor_if.sv
// PWM line in, frame measurements and door classification out.
interface servo_pwm_monitor_if #(
  parameter int unsigned CNT_W = 21
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] period_cycles;
  logic             sample_valid;
  logic [1:0]       door_state;
  logic             door_changed;
  logic             signal_lost;

  modport master (
    output pwm_in,
    input  high_cycles, period_cycles, sample_valid, door_state, door_changed, signal_lost
  );

  modport slave (
    input  pwm_in,
    output high_cycles, period_cycles, sample_valid, door_state, door_changed, signal_lost
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a delay flop for single-cycle edge strobes.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  // Shift the asynchronous input down the synchronizer chain.
  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and delay registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;
endmodule

// File: rtl/servo_pwm_monitor.sv
// Measures high time and period of a servo PWM line, classifies each frame as
// door open / closed / out-of-range and flags a dead or stuck line.
module servo_pwm_monitor
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned PERIOD_MIN  = NOM_PERIOD_CYC - 32'd50_000,
  parameter int unsigned PERIOD_MAX  = NOM_PERIOD_CYC + 32'd50_000,
  parameter int unsigned OPEN_MIN    = NOM_OPEN_CYC - 32'd10_000,
  parameter int unsigned OPEN_MAX    = NOM_OPEN_CYC + 32'd10_000,
  parameter int unsigned CLOSE_MIN   = NOM_CLOSE_CYC - 32'd10_000,
  parameter int unsigned CLOSE_MAX   = NOM_CLOSE_CYC + 32'd10_000,
  parameter int unsigned TIMEOUT_CYC = 32'd1_200_000
) (
  input logic                clk,
  input logic                reset,
  servo_pwm_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] PER_MIN_C    = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] PER_MAX_C    = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] OPEN_MIN_C   = CNT_W'(OPEN_MIN);
  localparam logic [CNT_W-1:0] OPEN_MAX_C   = CNT_W'(OPEN_MAX);
  localparam logic [CNT_W-1:0] CLOSE_MIN_C  = CNT_W'(CLOSE_MIN);
  localparam logic [CNT_W-1:0] CLOSE_MAX_C  = CNT_W'(CLOSE_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYC);

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] per);
    logic [1:0] cls;
    if ((per < PER_MIN_C) || (per > PER_MAX_C)) begin
      cls = DOOR_BAD;
    end else if ((hi >= OPEN_MIN_C) && (hi <= OPEN_MAX_C)) begin
      cls = DOOR_OPEN;
    end else if ((hi >= CLOSE_MIN_C) && (hi <= CLOSE_MAX_C)) begin
      cls = DOOR_CLOSED;
    end else begin
      cls = DOOR_BAD;
    end
    return cls;
  endfunction

  logic pwm_level_unused_s;
  logic rise_s, fall_s;
  logic [1:0] cls_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_cycles_q, high_cycles_d;
  logic [CNT_W-1:0] period_cycles_q, period_cycles_d;
  logic             sample_valid_q, sample_valid_d;
  logic [1:0]       door_state_q, door_state_d;
  logic             door_changed_q, door_changed_d;
  logic             signal_lost_q, signal_lost_d;

  // Reset high so a line that is already high at reset release gives no rise.
  sync_edge #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst   (reset),
    .d_in  (bus.pwm_in),
    .level (pwm_level_unused_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign cls_s = classify(hi_lat_q, cnt_q);

  // Frame measurement FSM; edges take priority over the timeout.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hi_lat_d        = hi_lat_q;
    high_cycles_d   = high_cycles_q;
    period_cycles_d = period_cycles_q;
    sample_valid_d  = 1'b0;
    door_state_d    = door_state_q;
    door_changed_d  = 1'b0;
    signal_lost_d   = signal_lost_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          hi_lat_d = cnt_q;
          cnt_d    = cnt_q + CNT_ONE;
          state_d  = ST_LOW;
        end else if (cnt_q == TIMEOUT_C) begin
          cnt_d         = CNT_ZERO;
          state_d       = ST_IDLE;
          signal_lost_d = 1'b1;
          door_state_d  = DOOR_UNKNOWN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          high_cycles_d   = hi_lat_q;
          period_cycles_d = cnt_q;
          sample_valid_d  = 1'b1;
          door_state_d    = cls_s;
          door_changed_d  = ((door_state_q == DOOR_OPEN) && (cls_s == DOOR_CLOSED)) ||
                            ((door_state_q == DOOR_CLOSED) && (cls_s == DOOR_OPEN));
          signal_lost_d   = 1'b0;
          cnt_d           = CNT_ONE;
          state_d         = ST_HIGH;
        end else if (cnt_q == TIMEOUT_C) begin
          cnt_d         = CNT_ZERO;
          state_d       = ST_IDLE;
          signal_lost_d = 1'b1;
          door_state_d  = DOOR_UNKNOWN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= CNT_ZERO;
      hi_lat_q        <= CNT_ZERO;
      high_cycles_q   <= CNT_ZERO;
      period_cycles_q <= CNT_ZERO;
      sample_valid_q  <= 1'b0;
      door_state_q    <= DOOR_UNKNOWN;
      door_changed_q  <= 1'b0;
      signal_lost_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hi_lat_q        <= hi_lat_d;
      high_cycles_q   <= high_cycles_d;
      period_cycles_q <= period_cycles_d;
      sample_valid_q  <= sample_valid_d;
      door_state_q    <= door_state_d;
      door_changed_q  <= door_changed_d;
      signal_lost_q   <= signal_lost_d;
    end
  end

  assign bus.high_cycles   = high_cycles_q;
  assign bus.period_cycles = period_cycles_q;
  assign bus.sample_valid  = sample_valid_q;
  assign bus.door_state    = door_state_q;
  assign bus.door_changed  = door_changed_q;
  assign bus.signal_lost   = signal_lost_q;
endmodule

// File: tb/tb_servo_pwm_monitor.sv
// Directed bench for servo_pwm_monitor with all cycle thresholds scaled by 1/1000.
module tb_servo_pwm_monitor;
  import servo_pkg::*;

  localparam int unsigned CW = 21;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;

  servo_pwm_monitor_if #(.CNT_W(CW)) bus ();

  servo_pwm_monitor #(
    .CNT_W       (CW),
    .PERIOD_MIN  (950),
    .PERIOD_MAX  (1050),
    .OPEN_MIN    (65),
    .OPEN_MAX    (85),
    .CLOSE_MIN   (160),
    .CLOSE_MAX   (180),
    .TIMEOUT_CYC (1200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (frame %0d): observed %0d expected %0d", tag, frame_no, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_sv, input int e_hi, input int e_per,
                           input logic [1:0] e_door, input logic e_chg, input logic e_lost);
    check({tag, "_sv"},    32'(bus.sample_valid),  32'(e_sv));
    check({tag, "_hi"},    32'(bus.high_cycles),   32'(e_hi));
    check({tag, "_per"},   32'(bus.period_cycles), 32'(e_per));
    check({tag, "_door"},  32'(bus.door_state),    32'(e_door));
    check({tag, "_chg"},   32'(bus.door_changed),  32'(e_chg));
    check({tag, "_lost"},  32'(bus.signal_lost),   32'(e_lost));
  endtask

  // One frame of h high / p period; the expectations describe the frame its rise completes.
  task automatic frame(input int h, input int p, input logic e_sv, input int e_hi, input int e_per,
                       input logic [1:0] e_door, input logic e_chg, input logic e_lost);
    frame_no++;
    bus.pwm_in = 1'b1;
    tick();
    tick();
    check("sv_early", 32'(bus.sample_valid), 32'd0);
    tick();
    check_all("pub", e_sv, e_hi, e_per, e_door, e_chg, e_lost);
    tick();
    check("sv_width",  32'(bus.sample_valid), 32'd0);
    check("chg_width", 32'(bus.door_changed), 32'd0);
    repeat (h - 4) tick();
    bus.pwm_in = 1'b0;
    repeat (p - h) tick();
  endtask

  initial begin
    int sv_seen;
    reset      = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) tick();
    check_all("reset", 1'b0, 0, 0, DOOR_UNKNOWN, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // Nominal open frames, then closed, then out-of-range and back.
    frame(75,  1000, 1'b0, 0,   0,    DOOR_UNKNOWN, 1'b0, 1'b0);
    frame(75,  1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);
    frame(75,  1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);
    frame(170, 1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);
    frame(170, 1000, 1'b1, 170, 1000, DOOR_CLOSED,  1'b1, 1'b0);
    frame(120, 1000, 1'b1, 170, 1000, DOOR_CLOSED,  1'b0, 1'b0);
    frame(75,  1000, 1'b1, 120, 1000, DOOR_BAD,     1'b0, 1'b0);
    frame(75,  1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);

    // Inclusive window and period boundaries.
    frame(85,  1050, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);
    frame(65,  950,  1'b1, 85,  1050, DOOR_OPEN,    1'b0, 1'b0);
    frame(180, 1000, 1'b1, 65,  950,  DOOR_OPEN,    1'b0, 1'b0);
    frame(64,  1000, 1'b1, 180, 1000, DOOR_CLOSED,  1'b1, 1'b0);
    frame(75,  1051, 1'b1, 64,  1000, DOOR_BAD,     1'b0, 1'b0);
    frame(160, 1000, 1'b1, 75,  1051, DOOR_BAD,     1'b0, 1'b0);
    frame(170, 949,  1'b1, 160, 1000, DOOR_CLOSED,  1'b0, 1'b0);
    frame(75,  1000, 1'b1, 170, 949,  DOOR_BAD,     1'b0, 1'b0);

    // Line held low: timeout fires 1203 cycles after the last rise was driven.
    repeat (202) tick();
    check_all("pre_timeout", 1'b0, 170, 949, DOOR_BAD, 1'b0, 1'b0);
    tick();
    check_all("timeout", 1'b0, 170, 949, DOOR_UNKNOWN, 1'b0, 1'b1);
    repeat (172) tick();
    check("lost_hold", 32'(bus.signal_lost), 32'd1);
    frame(75,  1000, 1'b0, 170, 949,  DOOR_UNKNOWN, 1'b0, 1'b1);
    frame(75,  1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);

    // One-cycle low glitch ten cycles into an open pulse.
    frame(10,  11,   1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);
    frame(64,  989,  1'b1, 10,  11,   DOOR_BAD,     1'b0, 1'b0);
    frame(75,  1000, 1'b1, 64,  989,  DOOR_BAD,     1'b0, 1'b0);

    // Reset in the middle of a high pulse, released with the line still high.
    frame_no++;
    bus.pwm_in = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_all("mid_reset", 1'b0, 0, 0, DOOR_UNKNOWN, 1'b0, 1'b0);
    reset   = 1'b0;
    sv_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.sample_valid === 1'b1) sv_seen++;
    end
    bus.pwm_in = 1'b0;
    for (int i = 0; i < 900; i++) begin
      tick();
      if (bus.sample_valid === 1'b1) sv_seen++;
    end
    check("post_reset_no_sample", 32'(sv_seen), 32'd0);
    frame(75,  1000, 1'b0, 0,   0,    DOOR_UNKNOWN, 1'b0, 1'b0);
    frame(75,  1000, 1'b1, 75,  1000, DOOR_OPEN,    1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
